pca_reg_ctrl: RTL

PCA_REG_CTRL -- requirements
Module: pca_reg_ctrl

---
 rtl/pca_reg_ctrl_if.sv | 37 +++
 rtl/pca_reg_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/pca_reg_ctrl_if.sv
// PCA register controller bus bundle.
// i2c_target side and register bank side in one interface.
interface pca_reg_ctrl_if;
  logic       start_i;
  logic       rw_i;
  logic       stop_i;
  logic       wr_byte_valid_i;
  logic [7:0] wr_byte_i;
  logic       rd_req_i;
  logic [7:0] rd_byte_o;
  logic       rd_byte_valid_o;
  logic       ai_en_i;
  logic [7:0] reg_addr_o;
  logic [7:0] reg_wdata_o;
  logic       reg_we_o;
  logic       reg_re_o;
  logic [7:0] reg_rdata_i;
  logic       busy_o;

  modport slave (
    input  start_i, rw_i, stop_i,
    input  wr_byte_valid_i, wr_byte_i,
    input  rd_req_i, ai_en_i, reg_rdata_i,
    output rd_byte_o, rd_byte_valid_o,
    output reg_addr_o, reg_wdata_o,
    output reg_we_o, reg_re_o, busy_o
  );

  modport master (
    output start_i, rw_i, stop_i,
    output wr_byte_valid_i, wr_byte_i,
    output rd_req_i, ai_en_i, reg_rdata_i,
    input  rd_byte_o, rd_byte_valid_o,
    input  reg_addr_o, reg_wdata_o,
    input  reg_we_o, reg_re_o, busy_o
  );
endinterface

// File: rtl/pca_reg_ctrl.sv
// PCA register controller: I2C byte stream to
// register bank pointer/write/read sequencing.
module pca_reg_ctrl #(
  parameter int unsigned LAST_ADDR = 69
) (
  input  logic           clk_i,
  input  logic           rst_i,
  pca_reg_ctrl_if.slave  bus
);

  localparam logic [7:0] LAST = 8'(LAST_ADDR);

  typedef enum logic [2:0] {
    IDLE, PTR, WDATA, READ, RFETCH
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] ptr_q, ptr_d;
  logic       phase_q, phase_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       we_q, we_d;
  logic       re_q, re_d;
  logic [7:0] rbyte_q, rbyte_d;
  logic       rvld_q, rvld_d;

  function automatic logic addr_ok(
    input logic [7:0] a
  );
    return (a <= LAST) || (a >= 8'd250);
  endfunction

  function automatic logic [7:0] ptr_inc(
    input logic [7:0] a
  );
    if (a == LAST || a == 8'hFF)
      return 8'h00;
    return a + 8'd1;
  endfunction

  // state, pointer and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= 8'h00;
      phase_q <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      rbyte_q <= 8'h00;
      rvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      phase_q <= phase_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      re_q    <= re_d;
      rbyte_q <= rbyte_d;
      rvld_q  <= rvld_d;
    end
  end

  // next state; START beats STOP, both beat FSM work
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    phase_d = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    rbyte_d = rbyte_q;
    rvld_d  = 1'b0;
    if (bus.start_i) begin
      state_d = bus.rw_i ? READ : PTR;
    end else if (bus.stop_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: ;
        PTR: begin
          if (bus.wr_byte_valid_i) begin
            ptr_d   = bus.wr_byte_i;
            state_d = WDATA;
          end
        end
        WDATA: begin
          if (bus.wr_byte_valid_i) begin
            addr_d  = ptr_q;
            wdata_d = bus.wr_byte_i;
            we_d    = addr_ok(ptr_q);
            if (bus.ai_en_i)
              ptr_d = ptr_inc(ptr_q);
          end
        end
        READ: begin
          if (bus.rd_req_i) begin
            addr_d  = ptr_q;
            re_d    = 1'b1;
            state_d = RFETCH;
          end
        end
        RFETCH: begin
          // phase 0: strobe out; phase 1: data in
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            rbyte_d = addr_ok(ptr_q) ?
                      bus.reg_rdata_i : 8'h00;
            rvld_d  = 1'b1;
            state_d = READ;
            if (bus.ai_en_i)
              ptr_d = ptr_inc(ptr_q);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.reg_addr_o      = addr_q;
  assign bus.reg_wdata_o     = wdata_q;
  assign bus.reg_we_o        = we_q;
  assign bus.reg_re_o        = re_q;
  assign bus.rd_byte_o       = rbyte_q;
  assign bus.rd_byte_valid_o = rvld_q;
  assign bus.busy_o          = (state_q != IDLE);

endmodule
